// File: rtl/rr_arbiter.sv
// rr_arbiter: N-writer busy/request arbiter feeding one shared write FIFO.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module rr_arbiter #(
  parameter int  NUM_WRITERS = 4,
  parameter int  DATA_W      = 8,
  localparam int IDX_W       = $clog2(NUM_WRITERS)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_WRITERS*DATA_W-1:0] i_data,
  input  logic [NUM_WRITERS-1:0]        i_req,
  input  logic                          i_full,
  output logic [NUM_WRITERS-1:0]        o_busy,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_we,
  output logic [IDX_W-1:0]              o_grant_id
);

  typedef enum logic [1:0] {
    ARB,
    GRANT,
    WRITE
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_WRITERS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [IDX_W-1:0]       gid_q, gid_d;
  logic [IDX_W-1:0]       win;
  logic                   grant_ok;

  assign grant_ok = (|i_req) && !i_full;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] rr_idx;

  // Descending scan so the nearest requester after ptr is assigned last.
  always_comb begin
    win    = '0;
    rr_idx = '0;
    for (int off = NUM_WRITERS; off >= 1; off--) begin
      rr_idx = IDX_W'((int'(ptr_q) + off) % NUM_WRITERS);
      if (i_req[rr_idx]) begin
        win = rr_idx;
      end
    end
  end

  assign ptr_d = (state_q == ARB && grant_ok) ? win : ptr_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr_q <= IDX_W'(NUM_WRITERS - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = NUM_WRITERS - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        win = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    data_d  = data_q;
    gid_d   = gid_q;
    unique case (state_q)
      ARB: begin
        if (grant_ok) begin
          state_d = GRANT;
          busy_d  = ~(NUM_WRITERS'(1) << win);
          gid_d   = win;
        end
      end
      GRANT: begin
        data_d  = i_data[int'(gid_q)*DATA_W +: DATA_W];
        busy_d  = '1;
        state_d = WRITE;
      end
      WRITE: begin
        if (!i_full) begin
          state_d = ARB;
        end
      end
      default: begin
        state_d = ARB;
        busy_d  = '1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ARB;
      busy_q  <= '1;
      data_q  <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
    end
  end

  assign o_we       = (state_q == WRITE) && !i_full;
  assign o_busy     = busy_q;
  assign o_data     = data_q;
  assign o_grant_id = gid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed and random stimulus against a behavioural model.
// Expected writes are queued at grant time and popped by a monitor.
module tb_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] data;
  logic [N-1:0]  req;
  logic          full;
  logic [N-1:0]  busy;
  logic [DW-1:0] odata;
  logic          we;
  logic [IW-1:0] gid;

  int errors = 0;
  int checks = 0;

  rr_arbiter #(.NUM_WRITERS(N), .DATA_W(DW)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_data    (data),
    .i_req     (req),
    .i_full    (full),
    .o_busy    (busy),
    .o_data    (odata),
    .o_we      (we),
    .o_grant_id(gid)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 writer granted, 2 write pending.
  int            mphase;
  int            mwin;
  int            mlast;
  logic [DW-1:0] mdata;
  logic [N-1:0]  served;
  int            q_id[$];
  logic [DW-1:0] q_data[$];
  int            gid_log[$];
  logic [DW-1:0] fifo[$];
  int            wcount = 0;

  task automatic chk(string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
`ifdef ARB_ROUND_ROBIN_EN
    for (int off = 1; off <= N; off++)
      if (r[(mlast + off) % N]) return (mlast + off) % N;
`else
    for (int k = 0; k < N; k++)
      if (r[k]) return k;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    mphase = 0;
    mwin   = 0;
    mlast  = N - 1;
    mdata  = '0;
    served = '0;
    q_id.delete();
    q_data.delete();
  endtask

  task automatic model_step();
    served = '0;
    case (mphase)
      0: if (req != '0 && !full) begin
        mwin   = pick(req);
        mlast  = mwin;
        mphase = 1;
      end
      1: begin
        mdata = data[mwin*DW +: DW];
        q_id.push_back(mwin);
        q_data.push_back(mdata);
        served[mwin] = 1'b1;
        mphase = 2;
      end
      default: if (!full) mphase = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    req  = '0;
    full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor / scoreboard on the falling edge.
  initial forever begin
    logic [N-1:0] eb;
    @(negedge clk);
    if (rst) begin
      chk("rst_busy", busy, 4'hF);
      chk("rst_we", we, 0);
    end else begin
      eb = (mphase == 1) ? ~(N'(1) << mwin) : 4'hF;
      chk("busy", busy, eb);
      chk("we", we, (mphase == 2 && !full));
      chk("grant_id", gid, mwin);
      chk("data_hold", odata, mdata);
      if (we) begin
        wcount++;
        fifo.push_back(odata);
        gid_log.push_back(int'(gid));
        if (q_id.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_we: got o_we=1 expected 0");
        end else begin
          chk("sb_id", gid, q_id.pop_front());
          chk("sb_data", odata, q_data.pop_front());
        end
      end
    end
  end

  initial begin
    int n0;
    int exp_order[5];
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    rst  = 1'b1;
    req  = '0;
    full = 1'b0;
    data = '0;
    model_reset();
    tick();
    tick();
    chk("reset_busy", busy, 4'hF);
    chk("reset_we", we, 0);
    chk("reset_data", odata, 0);
    chk("reset_gid", gid, 0);
    rst = 1'b0;

    // Single request from writer 2
    for (int k = 0; k < N; k++) data[k*DW +: DW] = DW'(8'hA0 + k);
    req = 4'b0100;
    tick();
    chk("t1_busy", busy, 4'b1011);
    tick();
    chk("t1_we", we, 1);
    chk("t1_data", odata, 8'hA2);
    chk("t1_gid", gid, 2);
    req = '0;
    repeat (3) tick();

    // All writers requesting continuously
    do_reset();
    gid_log.delete();
    req = 4'hF;
    repeat (15) tick();
    chk("t2_writes", gid_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < gid_log.size()) chk("t2_order", gid_log[i], exp_order[i]);
    req = '0;
    repeat (4) tick();

    // FIFO full stalls the write for 5 cycles
    data[0 +: DW] = 8'h5C;
    req = 4'b0001;
    tick();
    chk("t3_grant", busy, 4'b1110);
    full = 1'b1;
    req  = '0;
    n0   = fifo.size();
    repeat (5) begin
      tick();
      chk("t3_stall_we", we, 0);
      chk("t3_stall_data", odata, 8'h5C);
    end
    full = 1'b0;
    #1;
    chk("t3_we", we, 1);
    repeat (3) tick();
    chk("t3_fifo_count", fifo.size() - n0, 1);
    if (fifo.size() > n0) chk("t3_fifo_data", fifo[n0], 8'h5C);

    // FIFO full in ARB blocks any grant
    full = 1'b1;
    req  = 4'hF;
    n0   = wcount;
    repeat (4) begin
      tick();
      chk("t4_busy", busy, 4'hF);
    end
    chk("t4_no_we", wcount - n0, 0);
    full = 1'b0;
    tick();
    chk("t4_grant", busy != 4'hF, 1);
    req = '0;
    repeat (4) tick();

    // Asynchronous reset mid-GRANT
    do_reset();
    req = 4'hF;
    tick();
    tick();
    tick();
    tick();
    chk("t5_in_grant", busy != 4'hF, 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_rst_busy", busy, 4'hF);
    chk("t5_rst_we", we, 0);
    tick();
    rst = 1'b0;
    req = 4'hF;
    gid_log.delete();
    repeat (3) tick();
    chk("t5_writes", gid_log.size(), 1);
    if (gid_log.size() > 0) chk("t5_first", gid_log[0], 0);
    req = '0;
    repeat (4) tick();

    // Reset during a stalled write discards it
    req = 4'b1000;
    tick();
    full = 1'b1;
    req  = '0;
    tick();
    rst = 1'b1;
    model_reset();
    n0 = wcount;
    tick();
    rst  = 1'b0;
    full = 1'b0;
    repeat (4) tick();
    chk("t6_discard", wcount - n0, 0);

    // Randomized writers and FIFO backpressure
    repeat (400) begin
      tick();
      full = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) begin
        if (served[k]) begin
          req[k] = 1'($urandom_range(0, 1));
          data[k*DW +: DW] = DW'($urandom);
        end else if (!req[k] && $urandom_range(0, 2) == 0) begin
          req[k] = 1'b1;
          data[k*DW +: DW] = DW'($urandom);
        end
      end
    end
    req  = '0;
    full = 1'b0;
    repeat (6) tick();
    chk("sb_drained", q_id.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised N-writer to single-FIFO write arbiter with round-robin fairness and FIFO-full backpressure. It is the successor to the fixed two-writer arbiter, generalised in writer count and data width. Each writer uses the busy/request handshake: it raises a request, holds its data while its busy line is high, and is served when its busy line drops for one cycle. The block sits between the writer modules and the shared write FIFO, driving the FIFO's write-enable and write-data.

## Interface
- NUM_WRITERS, 4: number of writers; legal range 2..16
- DATA_W, 8: data width per writer
- IDX_W, $clog2(NUM_WRITERS): local width of the grant index (derived, not overridable)

- i_clk  in  1  clock; all state changes on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_data  in  NUM_WRITERS*DATA_W  writer k data at bits [k*DATA_W +: DATA_W]
- i_req  in  NUM_WRITERS  write request, one bit per writer
- i_full  in  1  FIFO full; no write may be issued while high
- o_busy  out  NUM_WRITERS  busy per writer; low for exactly one cycle = granted
- o_data  out  DATA_W  FIFO write data, registered
- o_we  out  1  FIFO write enable
- o_grant_id  out  IDX_W  index of the most recently granted writer, registered

## Operation
- States:
  - ARB: all o_busy high. If |i_req and !i_full, select the winner w, set o_busy[w]=0, o_grant_id=w, and go to GRANT.
  - GRANT: lasts exactly 1 cycle with o_busy[w]=0. At its closing edge: o_data <= i_data[w]; o_busy <= all ones; go to WRITE. Completes even if i_req[w] has dropped.
  - WRITE: o_we = !i_full (combinational from i_full). Stay in WRITE while i_full is high. When !i_full, the write is issued this cycle and the next state is ARB.
- Winner selection (round-robin):
  - Scan from ptr+1 upward, wrapping modulo NUM_WRITERS; the first set i_req wins.
  - ptr <= w on entry to GRANT.
- At most one o_busy bit is low at any time. o_busy is never low outside GRANT.
- o_data is held stable from the end of GRANT until the next GRANT.
- Reset (asynchronous, any state, including mid-GRANT or mid-WRITE):
  - state = ARB, o_busy = all ones, o_we = 0, o_data = 0, o_grant_id = 0, ptr = NUM_WRITERS-1 (so writer 0 has first priority).
  - A write in progress is discarded. No o_we pulse follows reset release without a new grant.

## Timing
- Request to grant: i_req[k] sampled high in ARB at edge t → o_busy[k] low during cycle t..t+1.
- Grant to write: o_we high in the cycle immediately after GRANT, provided i_full is low.
- Peak throughput: one write per 3 cycles (ARB, GRANT, WRITE).
- i_full high in ARB blocks any grant. i_full high in WRITE stalls with data held; there is no loss and no duplicate write.
- Simultaneous requests: exactly one writer is granted per ARB pass. The others keep their busy lines high and must hold their requests.
- Request and reset deassertion in the same cycle: reset wins, and the first ARB evaluation happens on the first edge after release.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin selection from ptr+1 as above.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest requesting index wins. ptr is not implemented. o_grant_id and all handshake timing are unchanged.

## Test plan
- Reset then single request: i_req=4'b0100 held → o_busy=4'b1011 for one cycle, then o_we=1 with o_data=i_data[2], o_grant_id=2.
- All request continuously, round-robin enabled, i_full=0 → grant order 0,1,2,3,0; one o_we every 3 cycles; o_data matches each writer's value.
- Same stimulus with the macro undefined → writer 0 granted every pass while its request stays high.
- i_full=1 during WRITE for 5 cycles → o_we=0 for 5 cycles and o_data stable, then a single o_we=1. A test FIFO records exactly one entry.
- i_full=1 in ARB with i_req=4'b1111 → o_busy stays 4'b1111 and no o_we until i_full falls.
- Assert i_reset mid-GRANT → o_busy=all ones and o_we=0 immediately (asynchronous). After release, with i_req=4'b1111, the first grant goes to writer 0.
